// File: rtl/approx_add_pkg.sv
// rtl/approx_add_pkg.sv - shared mode encoding and parameter limits for the approximate adder
package approx_add_pkg;

   typedef enum logic [1:0] {
      MODE_EXACT = 2'd0,
      MODE_LOA   = 2'd1,
      MODE_COPYB = 2'd2,
      MODE_TRUNC = 2'd3
   } mode_e;

   localparam int W_MIN      = 2;
   localparam int W_MAX      = 32;
   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 4;

endpackage

// File: rtl/approx_add_pipe_if.sv
// rtl/approx_add_pipe_if.sv - operand/result handshake bundle of the pipelined approximate adder
interface approx_add_pipe_if #(
   parameter int W = 12
) ();
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   mode;
   logic         out_valid;
   logic         out_ready;
   logic [W:0]   sum;
   logic [W:0]   err;

   modport master (
      output in_valid, a, b, mode, out_ready,
      input  in_ready, out_valid, sum, err
   );

   modport slave (
      input  in_valid, a, b, mode, out_ready,
      output in_ready, out_valid, sum, err
   );
endinterface

// File: rtl/approx_add_core.sv
// rtl/approx_add_core.sv - combinational approximate adder with exact shadow sum
module approx_add_core
   import approx_add_pkg::*;
#(
   parameter int W = 12,
   parameter int K = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  mode_e        mode,
   output logic [W:0]   sum,
   output logic [W:0]   exact
);

   assign exact = {1'b0, a} + {1'b0, b};

   if (K == 0) begin : g_exact
      assign sum = exact;
   end else begin : g_approx
      logic [K:0]   lo_exact;
      logic [K-1:0] lo;
      logic         c;
      logic [W-K:0] hi;

      assign lo_exact = {1'b0, a[K-1:0]} + {1'b0, b[K-1:0]};

      // Each mode only redefines the low bits and the carry into bit K.
      always_comb begin
         lo = lo_exact[K-1:0];
         c  = lo_exact[K];
         case (mode)
            MODE_LOA: begin
               lo = a[K-1:0] | b[K-1:0];
               c  = a[K-1] & b[K-1];
            end
            MODE_COPYB: begin
               lo = b[K-1:0];
               c  = a[K-1];
            end
            MODE_TRUNC: begin
               lo = '0;
               c  = 1'b0;
            end
            default: ;
         endcase
      end

      assign hi  = {1'b0, a[W-1:K]} + {1'b0, b[W-1:K]} + {{(W-K){1'b0}}, c};
      assign sum = {hi, lo};
   end

endmodule

// File: rtl/approx_add_pipe.sv
// rtl/approx_add_pipe.sv - pipelined approximate adder with stall handshake and on-line error statistics
module approx_add_pipe
   import approx_add_pkg::*;
#(
   parameter int W      = 12,
   parameter int K      = 4,
   parameter int STAGES = 2,
   parameter int ACC_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   approx_add_pipe_if.slave   bus,
   input  logic               stat_clr,
   output logic [W:0]         stat_wce,
   output logic [ACC_W-1:0]   stat_err_acc,
   output logic [ACC_W-1:0]   stat_nz_cnt,
   output logic [ACC_W-1:0]   stat_samples
);

   if (W < W_MIN || W > W_MAX || K < 0 || K > W - 1 ||
       STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_param
      $error("approx_add_pipe: illegal W/K/STAGES combination");
   end

   localparam int SW = ((ACC_W > W + 1) ? ACC_W : W + 1) + 1;
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   logic              en;
   logic              accept;
   logic [W:0]        core_sum;
   logic [W:0]        core_exact;
   logic [W:0]        err;
   logic [SW-1:0]     acc_sum;

   logic [STAGES-1:0] vld_q, vld_d;
   logic [W:0]        sum_q   [STAGES];
   logic [W:0]        sum_d   [STAGES];
   logic [W:0]        exact_q [STAGES];
   logic [W:0]        exact_d [STAGES];

   logic [W:0]        wce_q, wce_d;
   logic [ACC_W-1:0]  err_acc_q, err_acc_d;
   logic [ACC_W-1:0]  nz_cnt_q, nz_cnt_d;
   logic [ACC_W-1:0]  samples_q, samples_d;

   approx_add_core #(
      .W (W),
      .K (K)
   ) u_core (
      .a     (bus.a),
      .b     (bus.b),
      .mode  (mode_e'(bus.mode)),
      .sum   (core_sum),
      .exact (core_exact)
   );

   // The mode is consumed at stage 0, so only the two sums need to travel.
   assign en     = bus.out_ready | ~vld_q[STAGES-1];
   assign accept = vld_q[STAGES-1] & bus.out_ready;

   always_comb begin
      vld_d = vld_q;
      for (int i = 0; i < STAGES; i++) begin
         sum_d[i]   = sum_q[i];
         exact_d[i] = exact_q[i];
      end
      if (en) begin
         vld_d[0]   = bus.in_valid;
         sum_d[0]   = core_sum;
         exact_d[0] = core_exact;
         for (int i = 1; i < STAGES; i++) begin
            vld_d[i]   = vld_q[i-1];
            sum_d[i]   = sum_q[i-1];
            exact_d[i] = exact_q[i-1];
         end
      end
   end

   assign err = (exact_q[STAGES-1] >= sum_q[STAGES-1]) ?
                (exact_q[STAGES-1] - sum_q[STAGES-1]) :
                (sum_q[STAGES-1] - exact_q[STAGES-1]);

   assign acc_sum = SW'(err_acc_q) + SW'(err);

   // Clear has priority over an accept in the same cycle.
   always_comb begin
      wce_d     = wce_q;
      err_acc_d = err_acc_q;
      nz_cnt_d  = nz_cnt_q;
      samples_d = samples_q;
      if (stat_clr) begin
         wce_d     = '0;
         err_acc_d = '0;
         nz_cnt_d  = '0;
         samples_d = '0;
      end else if (accept) begin
         if (err > wce_q) begin
            wce_d = err;
         end
         err_acc_d = (acc_sum > SW'(ACC_MAX)) ? ACC_MAX : acc_sum[ACC_W-1:0];
         if (err != '0 && nz_cnt_q != ACC_MAX) begin
            nz_cnt_d = nz_cnt_q + ACC_W'(1);
         end
         if (samples_q != ACC_MAX) begin
            samples_d = samples_q + ACC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            sum_q[i]   <= '0;
            exact_q[i] <= '0;
         end
         wce_q     <= '0;
         err_acc_q <= '0;
         nz_cnt_q  <= '0;
         samples_q <= '0;
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < STAGES; i++) begin
            sum_q[i]   <= sum_d[i];
            exact_q[i] <= exact_d[i];
         end
         wce_q     <= wce_d;
         err_acc_q <= err_acc_d;
         nz_cnt_q  <= nz_cnt_d;
         samples_q <= samples_d;
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.sum       = sum_q[STAGES-1];
   assign bus.err       = err;

   assign stat_wce     = wce_q;
   assign stat_err_acc = err_acc_q;
   assign stat_nz_cnt  = nz_cnt_q;
   assign stat_samples = samples_q;

endmodule

// File: tb/tb_approx_add_pipe.sv
// tb/tb_approx_add_pipe.sv - scoreboard bench for approx_add_pipe with a reference model
`timescale 1ns/1ps
module tb_approx_add_pipe;

   localparam int W      = 12;
   localparam int K      = 4;
   localparam int STAGES = 2;
   localparam int ACC_W  = 32;
   localparam longint ACC_MAX = 64'hFFFF_FFFF;

   typedef struct {
      int unsigned s;
      int unsigned e;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             stat_clr;
   logic [W:0]       stat_wce;
   logic [ACC_W-1:0] stat_err_acc;
   logic [ACC_W-1:0] stat_nz_cnt;
   logic [ACC_W-1:0] stat_samples;

   int   checks = 0;
   int   errors = 0;
   bit   started = 0;
   bit   rand_done = 0;
   exp_t q[$];

   longint m_wce, m_acc, m_nz, m_smp;

   approx_add_pipe_if #(.W(W)) bus ();

   approx_add_pipe #(
      .W(W), .K(K), .STAGES(STAGES), .ACC_W(ACC_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .stat_clr     (stat_clr),
      .stat_wce     (stat_wce),
      .stat_err_acc (stat_err_acc),
      .stat_nz_cnt  (stat_nz_cnt),
      .stat_samples (stat_samples)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Reference: approximate sum built directly from the mode definitions.
   function automatic exp_t model(input int unsigned av, input int unsigned bv, input int md);
      exp_t r;
      int unsigned mask  = (1 << K) - 1;
      int unsigned exact = av + bv;
      int unsigned lo, c, hi;
      if (md == 0) begin
         r.s = exact;
      end else begin
         case (md)
            1:       begin lo = (av | bv) & mask; c = (av >> (K-1)) & (bv >> (K-1)) & 1; end
            2:       begin lo = bv & mask;        c = (av >> (K-1)) & 1; end
            default: begin lo = 0;                c = 0; end
         endcase
         hi  = (av >> K) + (bv >> K) + c;
         r.s = (hi << K) | lo;
      end
      r.e = (exact >= r.s) ? exact - r.s : r.s - exact;
      return r;
   endfunction

   task automatic send(input int unsigned av, input int unsigned bv, input int md,
                       input bit use_exp = 1'b0, input int unsigned es = 0, input int unsigned ee = 0);
      exp_t x;
      int   t;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = av[W-1:0];
      bus.b        = bv[W-1:0];
      bus.mode     = md[1:0];
      #4;
      t = 0;
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         #4;
         t++;
      end
      if (!bus.in_ready) begin
         fail("in_ready_timeout");
      end else begin
         x = model(av, bv, md);
         if (use_exp) begin
            x.s = es;
            x.e = ee;
         end
         q.push_back(x);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      stat_clr      = 1'b0;
      #4;
      t = 0;
      while ((q.size() != 0 || bus.out_valid) && t < 200) begin
         @(negedge clk);
         #4;
         t++;
      end
      if (t >= 200) fail("drain_timeout");
   endtask

   initial begin : monitor
      exp_t x;
      bit   have;
      wait (started);
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            q.delete();
            m_wce = 0; m_acc = 0; m_nz = 0; m_smp = 0;
            continue;
         end
         chk("stat_wce", stat_wce, m_wce);
         chk("stat_err_acc", stat_err_acc, m_acc);
         chk("stat_nz_cnt", stat_nz_cnt, m_nz);
         chk("stat_samples", stat_samples, m_smp);
         if (bus.out_valid && !bus.out_ready) begin
            chk("in_ready_during_stall", bus.in_ready, 0);
            if (q.size() != 0) begin
               chk("stall_sum", bus.sum, q[0].s);
               chk("stall_err", bus.err, q[0].e);
            end
         end
         have = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               fail("unexpected_output");
            end else begin
               x    = q.pop_front();
               have = 1'b1;
               chk("sum", bus.sum, x.s);
               chk("err", bus.err, x.e);
            end
         end
         if (stat_clr) begin
            m_wce = 0; m_acc = 0; m_nz = 0; m_smp = 0;
         end else if (have) begin
            if (x.e > m_wce) m_wce = x.e;
            m_acc = (m_acc + x.e > ACC_MAX) ? ACC_MAX : m_acc + x.e;
            if (x.e != 0 && m_nz < ACC_MAX) m_nz++;
            if (m_smp < ACC_MAX) m_smp++;
         end
      end
   end

   initial begin : watchdog
      #500000;
      fail("watchdog");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : main
      int t;
      rst_n         = 1'b0;
      stat_clr      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.mode      = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #4;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_sum", bus.sum, 0);
      chk("reset_err", bus.err, 0);
      chk("reset_in_ready", bus.in_ready, 1);
      chk("reset_stat_samples", stat_samples, 0);
      chk("reset_stat_wce", stat_wce, 0);
      started = 1'b1;

      // Latency: result visible exactly STAGES edges after the transfer.
      send(12'h00F, 12'h001, 2, 1'b1, 13'h011, 1);
      idle();
      #4;
      chk("latency_not_early", bus.out_valid, 0);
      @(negedge clk);
      #4;
      chk("latency_on_time", bus.out_valid, 1);
      drain();
      chk("t1_samples", stat_samples, 1);
      chk("t1_nz_cnt", stat_nz_cnt, 1);
      chk("t1_wce", stat_wce, 1);

      send(12'h00F, 12'h001, 1, 1'b1, 13'h00F, 1);
      send(12'hFFF, 12'h001, 0, 1'b1, 13'h1000, 0);
      send(12'hFFF, 12'hFFF, 3, 1'b1, 13'h1FE0, 30);
      drain();
      chk("trunc_wce", stat_wce, 30);
      send(12'h000, 12'h000, 2, 1'b1, 13'h000, 0);
      drain();
      chk("wce_sticky", stat_wce, 30);

      // Stream of 8 with out_ready dropped on cycles 3-5.
      @(negedge clk);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 3));
         end
         begin
            repeat (3) @(negedge clk);
            bus.out_ready = 1'b0;
            repeat (3) @(negedge clk);
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("stream_samples", stat_samples, 8);

      // stat_clr coinciding with an accept: clear wins.
      send(12'h0F0, 12'h00F, 3);
      idle();
      t = 0;
      while (!bus.out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus.out_valid) fail("clr_wait_timeout");
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      #4;
      chk("clr_samples", stat_samples, 0);
      chk("clr_err_acc", stat_err_acc, 0);
      chk("clr_nz_cnt", stat_nz_cnt, 0);
      chk("clr_wce", stat_wce, 0);
      send(12'h00F, 12'h001, 2, 1'b1, 13'h011, 1);
      drain();
      chk("post_clr_samples", stat_samples, 1);

      // Reset with two transfers held in the pipeline.
      @(negedge clk);
      bus.out_ready = 1'b0;
      send(12'h123, 12'h456, 1);
      send(12'h789, 12'h0AB, 2);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      #4;
      chk("midreset_out_valid", bus.out_valid, 0);
      chk("midreset_samples", stat_samples, 0);
      chk("midreset_wce", stat_wce, 0);
      repeat (8) begin
         @(negedge clk);
         #4;
         chk("no_stale_output", bus.out_valid, 0);
      end

      // Randomised traffic with back-pressure and occasional clears.
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               int unsigned av, bv;
               case ($urandom_range(0, 5))
                  0:       av = 0;
                  1:       av = 12'hFFF;
                  default: av = $urandom_range(0, 4095);
               endcase
               bv = ($urandom_range(0, 5) == 0) ? 12'hFFF : $urandom_range(0, 4095);
               send(av, bv, $urandom_range(0, 3));
               if ($urandom_range(0, 3) == 0) idle();
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               bus.out_ready = ($urandom_range(0, 9) < 7);
               stat_clr      = ($urandom_range(0, 49) == 0);
            end
         end
      join
      drain();
      chk("final_queue_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
